// File: rtl/int_issue_queue_pkg.sv
// isq_pkg: shared constants for the integer issue queue.
// Dispatch payload field offsets and default widths.
package isq_pkg;

    localparam int PAYLOAD_W_DEF = 241;
    localparam int PREG_W_DEF    = 6;

    localparam int LS_SIZE_LSB     = 0;
    localparam int IS_STORE_BIT    = 4;
    localparam int IS_LOAD_BIT     = 5;
    localparam int IS_IMM_BIT      = 6;
    localparam int IS_WORD_BIT     = 7;
    localparam int MULDIV_LSB      = 8;
    localparam int ALU_TYPE_LSB    = 21;
    localparam int IS_UNSIGNED_BIT = 32;
    localparam int CX_TYPE_LSB     = 33;
    localparam int IMM_LSB         = 39;
    localparam int SRC2_IS_REG_BIT = 103;
    localparam int SRC1_IS_REG_BIT = 104;
    localparam int PRS2_LSB        = 105;
    localparam int PRS1_LSB        = 111;
    localparam int NEED_TO_WB_BIT  = 117;
    localparam int OLD_PRD_LSB     = 118;
    localparam int PRD_LSB         = 124;
    localparam int LRD_LSB         = 130;
    localparam int LRS2_LSB        = 135;
    localparam int LRS1_LSB        = 140;
    localparam int INSTR_LSB       = 145;
    localparam int PC_LSB          = 177;

endpackage

// File: rtl/int_issue_queue_if.sv
// int_issue_queue_if: dispatch, wakeup and issue signals of the queue.
// master drives requests, slave is the queue itself.
interface int_issue_queue_if
    import isq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int PREG_W    = PREG_W_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                 flush;
    logic                 disp2isq_wren0;
    logic [PAYLOAD_W-1:0] disp2isq_wrdata0;
    logic                 bt2isq_src1_busy;
    logic                 bt2isq_src2_busy;
    logic                 isq2disp_ready;
    logic                 wb0_valid;
    logic                 wb1_valid;
    logic [PREG_W-1:0]    wb0_prd;
    logic [PREG_W-1:0]    wb1_prd;
    logic                 isq2exu_valid;
    logic                 isq2exu_ready;
    logic [PAYLOAD_W-1:0] isq2exu_data;
    logic [CNT_W-1:0]     isq_count;

    modport master (
        output flush, disp2isq_wren0, disp2isq_wrdata0,
        output bt2isq_src1_busy, bt2isq_src2_busy,
        output wb0_valid, wb1_valid, wb0_prd, wb1_prd,
        output isq2exu_ready,
        input  isq2disp_ready, isq2exu_valid, isq2exu_data, isq_count
    );

    modport slave (
        input  flush, disp2isq_wren0, disp2isq_wrdata0,
        input  bt2isq_src1_busy, bt2isq_src2_busy,
        input  wb0_valid, wb1_valid, wb0_prd, wb1_prd,
        input  isq2exu_ready,
        output isq2disp_ready, isq2exu_valid, isq2exu_data, isq_count
    );

endinterface

// File: rtl/int_issue_queue_select.sv
// isq_select: oldest-first priority encoder.
// Grants the lowest requesting index, one-hot and encoded.
module isq_select #(
    parameter int N     = 8,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Scan top-down so the lowest requesting index wins
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_grant    = '0;
                o_grant[i] = 1'b1;
                o_idx      = IDX_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/int_issue_queue.sv
// int_issue_queue: age-ordered collapsing integer issue queue.
// Wakes sources from two writeback buses, issues the oldest ready entry.
module int_issue_queue
    import isq_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int PREG_W    = PREG_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    int_issue_queue_if.slave isq_if
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [PAYLOAD_W-1:0] r_pay [DEPTH];
    logic [DEPTH-1:0]     r_valid;
    logic [DEPTH-1:0]     r_rdy1;
    logic [DEPTH-1:0]     r_rdy2;
    logic [CNT_W-1:0]     r_count;

    logic [PAYLOAD_W-1:0] w_ext_pay [DEPTH+1];
    logic [DEPTH:0]       w_ext_valid;
    logic [DEPTH:0]       w_ext_rdy1;
    logic [DEPTH:0]       w_ext_rdy2;
    logic [PAYLOAD_W-1:0] w_pay_n [DEPTH];
    logic [DEPTH-1:0]     w_valid_n;
    logic [DEPTH-1:0]     w_rdy1_n;
    logic [DEPTH-1:0]     w_rdy2_n;
    logic [DEPTH-1:0]     w_req;
    logic [DEPTH-1:0]     w_grant;
    logic [DEPTH-1:0]     w_shift;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic                 w_out_valid;
    logic                 w_issue;
    logic                 w_ready;
    logic                 w_enq;
    logic [CNT_W-1:0]     w_wr_idx;
    logic [CNT_W-1:0]     w_count_n;
    logic [PAYLOAD_W-1:0] w_sel_data;
    logic [PAYLOAD_W-1:0] w_in_pay;
    logic                 w_wb0_v;
    logic                 w_wb1_v;
    logic [PREG_W-1:0]    w_wb0_p;
    logic [PREG_W-1:0]    w_wb1_p;

    function automatic logic f_wake(input logic [PREG_W-1:0] prs);
        return (w_wb0_v && (w_wb0_p == prs)) ||
               (w_wb1_v && (w_wb1_p == prs));
    endfunction

    assign w_wb0_v  = isq_if.wb0_valid;
    assign w_wb1_v  = isq_if.wb1_valid;
    assign w_wb0_p  = isq_if.wb0_prd;
    assign w_wb1_p  = isq_if.wb1_prd;
    assign w_in_pay = isq_if.disp2isq_wrdata0;

    assign w_req = r_valid & r_rdy1 & r_rdy2;

    isq_select #(
        .N     (DEPTH),
        .IDX_W (IDX_W)
    ) u_sel (
        .i_req   (w_req),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign w_out_valid = w_any && !isq_if.flush && !reset;
    assign w_issue     = w_out_valid && isq_if.isq2exu_ready;
    assign w_ready     = (r_count != CNT_W'(DEPTH)) && !reset;
    assign w_enq       = isq_if.disp2isq_wren0 && w_ready && !isq_if.flush;
    assign w_wr_idx    = r_count - CNT_W'(w_issue);
    assign w_count_n   = r_count + CNT_W'(w_enq) - CNT_W'(w_issue);

    assign isq_if.isq2disp_ready = w_ready;
    assign isq_if.isq2exu_valid  = w_out_valid;
    assign isq_if.isq2exu_data   = w_out_valid ? w_sel_data : '0;
    assign isq_if.isq_count      = r_count;

    // AND-OR mux of the granted entry's payload
    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_grant[i]) begin
                w_sel_data = w_sel_data | r_pay[i];
            end
        end
    end

    // Pad entry state with an empty slot so the top entry shifts in nothing
    always_comb begin
        w_ext_valid = {1'b0, r_valid};
        w_ext_rdy1  = {1'b0, r_rdy1};
        w_ext_rdy2  = {1'b0, r_rdy2};
        for (int i = 0; i < DEPTH; i++) begin
            w_ext_pay[i] = r_pay[i];
        end
        w_ext_pay[DEPTH] = '0;
    end

    // Slots at or above the issued index take their upper neighbour
    always_comb begin
        w_shift = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_shift[i] = w_issue && (i >= int'(w_idx));
        end
    end

    // Collapse, then wakeup on the shifted copies, then the enqueue write
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_valid_n[i] = w_shift[i] ? w_ext_valid[i+1] : w_ext_valid[i];
            w_pay_n[i]   = w_shift[i] ? w_ext_pay[i+1]   : w_ext_pay[i];
            w_rdy1_n[i]  = (w_shift[i] ? w_ext_rdy1[i+1] : w_ext_rdy1[i]) ||
                           f_wake(w_pay_n[i][PRS1_LSB +: PREG_W]);
            w_rdy2_n[i]  = (w_shift[i] ? w_ext_rdy2[i+1] : w_ext_rdy2[i]) ||
                           f_wake(w_pay_n[i][PRS2_LSB +: PREG_W]);
            if (w_enq && (CNT_W'(i) == w_wr_idx)) begin
                w_valid_n[i] = 1'b1;
                w_pay_n[i]   = w_in_pay;
                w_rdy1_n[i]  = !w_in_pay[SRC1_IS_REG_BIT] ||
                               !isq_if.bt2isq_src1_busy ||
                               f_wake(w_in_pay[PRS1_LSB +: PREG_W]);
                w_rdy2_n[i]  = !w_in_pay[SRC2_IS_REG_BIT] ||
                               !isq_if.bt2isq_src2_busy ||
                               f_wake(w_in_pay[PRS2_LSB +: PREG_W]);
            end
        end
    end

    // Occupancy state; reset and flush both empty the queue
    always_ff @(posedge clock) begin
        if (reset || isq_if.flush) begin
            r_valid <= '0;
            r_count <= '0;
        end else begin
            r_valid <= w_valid_n;
            r_count <= w_count_n;
        end
    end

    // Payload and readiness carry no reset; validity qualifies them
    always_ff @(posedge clock) begin
        r_rdy1 <= w_rdy1_n;
        r_rdy2 <= w_rdy2_n;
        for (int i = 0; i < DEPTH; i++) begin
            r_pay[i] <= w_pay_n[i];
        end
    end

endmodule
